ioctl_loader_bridge: RTL and testbench
======================================

Name: ioctl_loader_bridge

Overview:
Buffers the byte stream from the hps_io ioctl download port and delivers it to the PC88 core loader port (LOADER_ADR/WDAT/WR/ACK/OE/DONE). It uses a small FIFO and an issue/acknowledge state machine. It throttles the host through ioctl_wait and flags overruns. It replaces the inline ldr_wr/ldr_done glue in the emu top level.

Parameters:
AW, 19, loader address width; ioctl_addr[AW-1:0] is forwarded
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)
WAIT_MARGIN, 2, ioctl_wait asserts when occupancy >= 2**DEPTH_LOG2 - WAIT_MARGIN

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  backpressure to hps_io
ldr_adr  out  AW  address to core
ldr_wdat  out  8  data to core
ldr_wr  out  1  write request, held until acknowledged
ldr_ack  in  1  core acknowledge (level; rising edge counts)
ldr_oe  out  1  loader owns memory bus
ldr_done  out  1  load complete, sticky
ldr_overflow  out  1  sticky: a byte was dropped on a full FIFO

Behaviour:
- Reset (async assert, sync release): FIFO emptied. All outputs are 0. State is IDLE. ack_d = 0. dl_seen = 0.
- FIFO entry is {ioctl_addr[AW-1:0], ioctl_dout}.
- Push condition: ioctl_wr & ~ldr_done.
- Push while full: the byte is dropped and ldr_overflow is set to 1. The overflow flag stays set until reset.
- Push and pop in the same cycle are both legal. Occupancy is then unchanged.
- ioctl_wait is registered from occupancy after the update: 1 iff count >= DEPTH - WAIT_MARGIN.
- ack_d <= ldr_ack. ack_rise = ldr_ack & ~ack_d.
- FSM IDLE:
  - If the FIFO is non-empty: latch head into ldr_adr/ldr_wdat, set ldr_wr = 1, go to WAIT_ACK.
  - Latency: a byte pushed into an empty FIFO at edge N gives ldr_wr = 1 after edge N+1.
- FSM WAIT_ACK:
  - Hold ldr_adr/ldr_wdat/ldr_wr stable.
  - On ack_rise: ldr_wr = 0, pop head, go to IDLE.
  - The next entry issues no earlier than one cycle later, so ldr_wr always shows at least one low cycle between bytes.
- ack_rise in IDLE is ignored. An ack already high on entry to WAIT_ACK does not count; a fresh rising edge is required.
- dl_seen: set on the rising edge of ioctl_download.
- ldr_done: set (sticky until reset) when dl_seen = 1, ioctl_download = 0, the FIFO is empty and the state is IDLE. A falling edge of download with bytes still pending drains them first.
- ldr_oe = dl_seen & ~ldr_done (registered).
- ioctl_wr after ldr_done is ignored; no overflow is flagged.
- A new download after done is ignored.
- Address wrap: bits above AW-1 are discarded without checking.
- Reset mid-transfer: pending bytes are lost and ldr_wr drops immediately (async).

Optional Feature:
- Macro: LDR_CHECKSUM_EN.
- When defined, two extra output ports are added:
  - ldr_sum[7:0]: modulo-256 sum of bytes acknowledged by the core.
  - ldr_count[23:0]: count of bytes acknowledged; saturates at all-ones.
- Both update on the ack_rise that pops an entry and reset to 0.
- When undefined, the ports and logic are absent and the other behaviour is identical.

Test Plan:
- Single byte: download rises, then ioctl_wr with addr 0x00010/data 0xA5; core acks 3 cycles after ldr_wr -> ldr_wr high on the next cycle with ldr_adr = 0x00010, ldr_wdat = 0xA5; ldr_wr low the cycle after ack_rise; after download falls, ldr_done = 1 and ldr_oe = 0.
- Burst of 8 back-to-back bytes, core ack delayed 10 cycles each -> ioctl_wait = 1 once occupancy reaches 6; no overflow; all 8 bytes are delivered in order.
- Same burst ignoring ioctl_wait, 12 bytes with no acks -> ldr_overflow = 1; exactly 8 bytes are delivered after acks resume (bytes 0-7).
- ldr_ack held high from before the request -> no pop until ack goes low and then high again.
- Download falls with 3 bytes queued -> ldr_done stays 0 until the third ack, then 1; a later ioctl_wr is not delivered.
- Reset asserted in WAIT_ACK -> ldr_wr, ldr_oe, ioctl_wait and ldr_done are 0 in the same cycle; the FIFO is empty after release.
- With LDR_CHECKSUM_EN, bytes 0xFF, 0x02 delivered -> ldr_sum = 0x01, ldr_count = 2.

Source files
------------

// File: rtl/ioctl_loader_bridge.sv
// ioctl_loader_bridge: buffers hps_io ioctl download bytes in a small FIFO and
// hands them one at a time to the PC88 loader port with an issue/acknowledge
// handshake. It throttles the host via ioctl_wait and flags dropped bytes.
// Optional build macro LDR_CHECKSUM_EN adds ldr_sum / ldr_count outputs.
module ioctl_loader_bridge #(
  parameter int unsigned AW          = 19,
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned WAIT_MARGIN = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] ldr_adr,
  output logic [7:0]    ldr_wdat,
  output logic          ldr_wr,
  input  logic          ldr_ack,
  output logic          ldr_oe,
  output logic          ldr_done,
  output logic          ldr_overflow
`ifdef LDR_CHECKSUM_EN
  ,
  output logic [7:0]    ldr_sum,
  output logic [23:0]   ldr_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = AW + 8;
  localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] C_WAIT_TH = CW'(DEPTH - WAIT_MARGIN);

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  state_t                r_state;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_wait;
  logic                  r_overflow;
  logic [AW-1:0]         r_adr;
  logic [7:0]            r_wdat;
  logic                  r_wr;
  logic                  r_ack_d;
  logic                  r_dl_d;
  logic                  r_dl_seen;
  logic                  r_done;
  logic                  r_oe;

  logic                  w_push_req;
  logic                  w_full;
  logic                  w_push;
  logic                  w_ack_rise;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nx;
  logic                  w_dl_seen_nx;
  logic                  w_done_nx;

  assign w_push_req   = ioctl_wr & ~r_done;
  assign w_full       = (r_count == C_FULL);
  assign w_push       = w_push_req & ~w_full;
  assign w_ack_rise   = ldr_ack & ~r_ack_d;
  assign w_pop        = (r_state == S_WAIT_ACK) & w_ack_rise;
  assign w_dl_seen_nx = r_dl_seen | (ioctl_download & ~r_dl_d);
  assign w_done_nx    = r_done | (r_dl_seen & ~ioctl_download &
                                  (r_count == '0) & (r_state == S_IDLE));

  // Upper address bits beyond the loader width are intentionally discarded.
  if (AW < 25) begin : g_addr_unused
    logic w_unused_addr;
    assign w_unused_addr = ^ioctl_addr[24:AW];
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CW'(1);
      2'b01:   w_count_nx = r_count - CW'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // FIFO storage; contents are don't-care until written so no reset.
  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
  end

  // FIFO pointers, occupancy, host backpressure and sticky overflow.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wait     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      r_count <= w_count_nx;
      r_wait  <= (w_count_nx >= C_WAIT_TH);
      if (w_push_req & w_full) r_overflow <= 1'b1;
    end
  end

  // Issue/acknowledge FSM; the head stays in the FIFO until acknowledged.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            {r_adr, r_wdat} <= r_mem[r_rptr];
            r_wr            <= 1'b1;
            r_state         <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (w_ack_rise) begin
            r_wr    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Edge detectors and download-lifetime flags (done/oe are sticky per load).
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ack_d   <= 1'b0;
      r_dl_d    <= 1'b0;
      r_dl_seen <= 1'b0;
      r_done    <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      r_ack_d   <= ldr_ack;
      r_dl_d    <= ioctl_download;
      r_dl_seen <= w_dl_seen_nx;
      r_done    <= w_done_nx;
      r_oe      <= w_dl_seen_nx & ~w_done_nx;
    end
  end

`ifdef LDR_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic [23:0] r_bytes;

  // Running sum and saturating count of acknowledged bytes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sum   <= '0;
      r_bytes <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + r_wdat;
      if (r_bytes != '1) r_bytes <= r_bytes + 24'd1;
    end
  end

  assign ldr_sum   = r_sum;
  assign ldr_count = r_bytes;
`endif

  assign ioctl_wait   = r_wait;
  assign ldr_adr      = r_adr;
  assign ldr_wdat     = r_wdat;
  assign ldr_wr       = r_wr;
  assign ldr_oe       = r_oe;
  assign ldr_done     = r_done;
  assign ldr_overflow = r_overflow;

endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Self-checking bench for ioctl_loader_bridge: directed scenarios plus random
// traffic, compared every cycle against a queue-based transaction model.
module tb_ioctl_loader_bridge;

  localparam int unsigned AW = 19;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] ldr_adr;
  logic [7:0]    ldr_wdat;
  logic          ldr_wr;
  logic          ldr_ack;
  logic          ldr_oe;
  logic          ldr_done;
  logic          ldr_overflow;
`ifdef LDR_CHECKSUM_EN
  logic [7:0]    ldr_sum;
  logic [23:0]   ldr_count;
`endif

  always #5 clk_sys = ~clk_sys;

  ioctl_loader_bridge #(.AW(AW), .DEPTH_LOG2(3), .WAIT_MARGIN(2)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_adr        (ldr_adr),
    .ldr_wdat       (ldr_wdat),
    .ldr_wr         (ldr_wr),
    .ldr_ack        (ldr_ack),
    .ldr_oe         (ldr_oe),
    .ldr_done       (ldr_done),
    .ldr_overflow   (ldr_overflow)
`ifdef LDR_CHECKSUM_EN
    ,
    .ldr_sum        (ldr_sum),
    .ldr_count      (ldr_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending bytes as a queue; the head is in flight while busy.
  logic [26:0] m_q[$];
  logic [26:0] m_cur;
  bit          m_busy, m_ack_prev, m_dl_prev, m_dl_seen, m_done, m_ovf, m_oe, m_wait;
  logic [7:0]  m_sum;
  int unsigned m_cnt;

  // Host/core stimulus state.
  logic [24:0] s_addr[$];
  logic [7:0]  s_data[$];
  bit          respect_wait, ack_en, ack_hold, prev_wr, saw_wait;
  int          wr_pct, ack_delay, wcnt, deliv;

  task automatic model_clear();
    m_q.delete();
    m_cur = '0; m_busy = 0; m_ack_prev = 0; m_dl_prev = 0; m_dl_seen = 0;
    m_done = 0; m_ovf = 0; m_oe = 0; m_wait = 0; m_sum = '0; m_cnt = 0;
  endtask

  // Predicts the effect of the upcoming clock edge from the inputs now driven.
  task automatic model_edge();
    bit rise, pop, issue, push, done_set;
    int unsigned sz;
    sz       = m_q.size();
    rise     = ldr_ack && !m_ack_prev;
    pop      = m_busy && rise;
    issue    = !m_busy && (sz > 0);
    push     = ioctl_wr && !m_done;
    done_set = m_dl_seen && !ioctl_download && (sz == 0) && !m_busy;
    if (issue) begin
      m_cur  = m_q[0];
      m_busy = 1;
    end else if (pop) begin
      m_busy = 0;
      m_sum  = m_sum + m_q[0][7:0];
      if (m_cnt < 24'hFFFFFF) m_cnt++;
      void'(m_q.pop_front());
    end
    if (push) begin
      if (sz == 8) m_ovf = 1;
      else m_q.push_back({ioctl_addr[AW-1:0], ioctl_dout});
    end
    if (ioctl_download && !m_dl_prev) m_dl_seen = 1;
    if (done_set) m_done = 1;
    m_oe       = m_dl_seen && !m_done;
    m_wait     = (m_q.size() >= 6);
    m_ack_prev = ldr_ack;
    m_dl_prev  = ioctl_download;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_sys);
    #1;
    check("wr", ldr_wr, m_busy);
    if (m_busy) begin
      check("adr", ldr_adr, m_cur[26:8]);
      check("wdat", ldr_wdat, m_cur[7:0]);
    end
    check("wait", ioctl_wait, m_wait);
    check("ovf", ldr_overflow, m_ovf);
    check("done", ldr_done, m_done);
    check("oe", ldr_oe, m_oe);
`ifdef LDR_CHECKSUM_EN
    check("sum", ldr_sum, m_sum);
    check("count", ldr_count, m_cnt);
`endif
    if (ldr_wr && !prev_wr) deliv++;
    prev_wr = ldr_wr;
    if (ioctl_wait) saw_wait = 1;
    // host: one-cycle strobes from the send queue
    ioctl_wr = 1'b0;
    if (s_addr.size() > 0 && (!respect_wait || !ioctl_wait) &&
        $urandom_range(99) < wr_pct) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = s_addr.pop_front();
      ioctl_dout = s_data.pop_front();
    end
    // core: single-cycle ack pulse some cycles after a request appears
    if (ack_hold) ldr_ack = 1'b1;
    else if (!ack_en) ldr_ack = 1'b0;
    else if (ldr_ack) begin
      ldr_ack = 1'b0;
      wcnt    = 0;
    end else if (ldr_wr) begin
      if (wcnt >= ack_delay) ldr_ack = 1'b1;
      else wcnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic enqueue(input logic [24:0] addr, input logic [7:0] data);
    s_addr.push_back(addr);
    s_data.push_back(data);
  endtask

  task automatic enqueue_rand(input int n, input logic [24:0] base);
    for (int i = 0; i < n; i++) enqueue(base + 25'(i), 8'($urandom));
  endtask

  // Asserts reset between edges and checks the asynchronous clear immediately.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_wr", ldr_wr, 1'b0);
    check("rst_oe", ldr_oe, 1'b0);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_done", ldr_done, 1'b0);
    check("rst_ovf", ldr_overflow, 1'b0);
    model_clear();
    s_addr.delete();
    s_data.delete();
    ioctl_wr = 1'b0;
    ldr_ack  = 1'b0;
    ack_hold = 0; ack_en = 1; ack_delay = 0; wcnt = 0;
    respect_wait = 1; wr_pct = 100; prev_wr = 0; deliv = 0; saw_wait = 0;
    @(posedge clk_sys);
    #1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ldr_ack = 1'b0;
    do_reset();

    // single byte with exact latency
    ioctl_download = 1'b1;
    ack_delay = 3;
    run(2);
    enqueue(25'h0000010, 8'hA5);
    cycle();                       // strobe driven for the next edge
    cycle();                       // edge N: byte pushed
    check("lat_n", ldr_wr, 1'b0);
    cycle();                       // edge N+1: request issued
    check("lat_n1", ldr_wr, 1'b1);
    check("single_adr", ldr_adr, 19'h00010);
    check("single_wdat", ldr_wdat, 8'hA5);
    run(20);
    ioctl_download = 1'b0;
    run(4);
    check("single_done", ldr_done, 1'b1);
    check("single_oe", ldr_oe, 1'b0);
    check("single_deliv", deliv, 1);

    // burst of 8 with slow core
    do_reset();
    ioctl_download = 1'b1;
    cycle();
    respect_wait = 0; ack_delay = 10;
    enqueue_rand(8, 25'h0000100);
    run(200);
    check("burst_wait_seen", saw_wait, 1'b1);
    check("burst_ovf", ldr_overflow, 1'b0);
    check("burst_deliv", deliv, 8);

    // 12 bytes, no acks: overflow, only first 8 delivered
    do_reset();
    ioctl_download = 1'b1;
    respect_wait = 0; ack_en = 0;
    cycle();
    enqueue_rand(12, 25'h0000200);
    run(20);
    check("ovf_set", ldr_overflow, 1'b1);
    ack_en = 1; ack_delay = 1;
    run(100);
    check("ovf_deliv", deliv, 8);
    check("ovf_sticky", ldr_overflow, 1'b1);

    // ack already high before the request
    do_reset();
    ioctl_download = 1'b1;
    ack_hold = 1;
    cycle();
    enqueue(25'h1ABCDEF, 8'h3C);   // upper address bits are discarded
    run(12);
    check("hold_nopop", ldr_wr, 1'b1);
    check("hold_wrap_adr", ldr_adr, 19'h3CDEF);
    ack_hold = 0; ack_delay = 0;
    run(10);
    check("hold_popped", ldr_wr, 1'b0);
    check("hold_deliv", deliv, 1);

    // download falls with 3 bytes pending
    do_reset();
    ioctl_download = 1'b1;
    ack_en = 0;
    cycle();
    enqueue_rand(3, 25'h0000300);
    run(6);
    ioctl_download = 1'b0;
    run(5);
    check("drain_not_done", ldr_done, 1'b0);
    ack_en = 1; ack_delay = 2;
    run(40);
    check("drain_done", ldr_done, 1'b1);
    enqueue(25'h0000400, 8'h77);
    run(10);
    check("drain_deliv", deliv, 3);
    check("drain_late_ovf", ldr_overflow, 1'b0);
    ioctl_download = 1'b1;         // a new download after done is ignored
    run(4);
    check("redl_oe", ldr_oe, 1'b0);

    // reset while waiting for ack
    do_reset();
    ioctl_download = 1'b1;
    ack_en = 0;
    cycle();
    enqueue_rand(2, 25'h0000500);
    run(6);
    check("pre_rst_wr", ldr_wr, 1'b1);
    do_reset();
    run(6);
    check("post_rst_wr", ldr_wr, 1'b0);
    check("post_rst_wait", ioctl_wait, 1'b0);

`ifdef LDR_CHECKSUM_EN
    do_reset();
    ioctl_download = 1'b1;
    cycle();
    enqueue(25'h0000600, 8'hFF);
    enqueue(25'h0000601, 8'h02);
    run(30);
    check("csum_sum", ldr_sum, 8'h01);
    check("csum_count", ldr_count, 24'd2);
`endif

    // randomized loads
    for (int r = 0; r < 8; r++) begin
      int guard;
      do_reset();
      ioctl_download = 1'b1;
      cycle();
      respect_wait = bit'($urandom_range(1));
      wr_pct       = int'($urandom_range(30, 100));
      ack_delay    = int'($urandom_range(0, 5));
      enqueue_rand(int'($urandom_range(10, 40)), 25'($urandom));
      guard = 0;
      while (s_addr.size() > 0 && guard < 3000) begin
        cycle();
        guard++;
      end
      check("rnd_sent", s_addr.size(), 0);
      run(int'($urandom_range(0, 20)));
      ioctl_download = 1'b0;
      run(400);
      check("rnd_done", ldr_done, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
